// File: rtl/clk_sw_pkg.sv
// ============================================================================
// clk_sw_pkg: shared state encoding and counter sizing for clk_switch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_sw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    SETTLE   = 2'd2,
    DWELL    = 2'd3
  } sw_state_e;

  // One counter is shared by every timed state, so it must hold the largest count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff: single-bit two-flop synchronizer, clears to 0 on reset
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
// ============================================================================
// clk_switch_ctrl: request sequencer for a glitch-free two-clock mux
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter logic RESET_SEL      = 1'b0,
  parameter int   SETTLE_CYCLES  = 4,
  parameter int   MIN_DWELL      = 2,
  parameter int   TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic mux_sel,
  input  logic mux_stat0,
  input  logic mux_stat1,
  output logic cur_sel,
  output logic sw_done,
  output logic sw_err
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, MIN_DWELL, TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WAIT_ACK = WAIT_ACK;
  localparam logic [1:0] ST_SETTLE   = SETTLE;
  localparam logic [1:0] ST_DWELL    = DWELL;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // MIN_DWELL of 0 or 1 both leave DWELL after a single cycle.
  localparam logic [CNT_W-1:0] DWELL_LAST   = (MIN_DWELL > 1) ? CNT_W'(MIN_DWELL - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             target;
  logic             stat0_s;
  logic             stat1_s;
  logic             accept;
  logic             ack;

  sync_2ff u_sync0 (
    .clk (clk),
    .rst (rst),
    .d   (mux_stat0),
    .q   (stat0_s)
  );

  sync_2ff u_sync1 (
    .clk (clk),
    .rst (rst),
    .d   (mux_stat1),
    .q   (stat1_s)
  );

  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Handover is confirmed only when the target branch runs and the other is fully off.
  assign ack = target ? (stat1_s && !stat0_s) : (stat0_s && !stat1_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      target  <= RESET_SEL;
      mux_sel <= RESET_SEL;
      cur_sel <= RESET_SEL;
      sw_done <= 1'b0;
      sw_err  <= 1'b0;
    end else begin
      sw_done <= 1'b0;
      sw_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_sel == cur_sel) begin
              sw_done <= 1'b1;
            end else begin
              mux_sel <= req_sel;
              target  <= req_sel;
              cnt     <= '0;
              state   <= ST_WAIT_ACK;
            end
          end
        end

        ST_WAIT_ACK: begin
          if (ack) begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end else if (cnt == TIMEOUT_LAST) begin
            sw_err  <= 1'b1;
            mux_sel <= cur_sel;
            cnt     <= '0;
            state   <= ST_DWELL;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cur_sel <= target;
            sw_done <= 1'b1;
            cnt     <= '0;
            state   <= ST_DWELL;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_DWELL: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
// ============================================================================
// tb_clk_switch_ctrl: directed self-checking bench for clk_switch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_switch_ctrl;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel   = 1'b0;
  logic req_ready, mux_sel, mux_stat0, mux_stat1, cur_sel, sw_done, sw_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Mux model: old branch drops 2 cycles after mux_sel changes, new one rises at 3.
  logic [2:0] hist     = 3'b000;
  logic       model_en = 1'b1;

  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   tog_cnt  = 0;
  int   both_cnt = 0;
  logic prev_sel = 1'b0;

  always #5 clk = ~clk;

  clk_switch_ctrl #(
    .RESET_SEL      (1'b0),
    .SETTLE_CYCLES  (4),
    .MIN_DWELL      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_stat0 (mux_stat0),
    .mux_stat1 (mux_stat1),
    .cur_sel   (cur_sel),
    .sw_done   (sw_done),
    .sw_err    (sw_err)
  );

  assign mux_stat0 = ~hist[1] & ~hist[2];
  assign mux_stat1 =  hist[1] &  hist[2];

  always @(posedge clk) begin
    if (model_en) hist <= {hist[1:0], mux_sel};
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (sw_done) done_cnt <= done_cnt + 1;
    if (sw_err) err_cnt <= err_cnt + 1;
    if (sw_done && sw_err) both_cnt <= both_cnt + 1;
    if (mux_sel !== prev_sel) tog_cnt <= tog_cnt + 1;
    prev_sel <= mux_sel;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_evt(input int limit, output int n, output logic saw_done, output logic saw_err);
    n = 0;
    saw_done = 1'b0;
    saw_err = 1'b0;
    while (n < limit && !saw_done && !saw_err) begin
      tick;
      n++;
      saw_done = sw_done;
      saw_err = sw_err;
    end
    check("evt_seen", 32'(saw_done | saw_err), 32'd1);
  endtask

  initial begin
    int   n;
    logic d, e;
    int   done_base, err_base, acc_base, tog_base;

    // 1. reset
    rst = 1'b1;
    repeat (3) tick;
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_cur_sel", 32'(cur_sel), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_done", 32'(sw_done), 32'd0);
    rst = 1'b0;
    tick;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // 2. same-select request
    req_sel = 1'b0;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    check("same_done", 32'(sw_done), 32'd1);
    check("same_mux_sel", 32'(mux_sel), 32'd0);
    check("same_ready", 32'(req_ready), 32'd1);
    tick;
    check("same_done_pulse", 32'(sw_done), 32'd0);

    // 3. switch 0 -> 1
    req_sel = 1'b1;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    check("sw_mux_sel", 32'(mux_sel), 32'd1);
    check("sw_cur_before", 32'(cur_sel), 32'd0);
    wait_evt(40, n, d, e);
    check("sw_latency", 32'(n), 32'd10);
    check("sw_done_seen", 32'(d), 32'd1);
    check("sw_no_err", 32'(e), 32'd0);
    check("sw_cur_sel", 32'(cur_sel), 32'd1);
    tick;
    check("sw_ready_dwell", 32'(req_ready), 32'd0);
    tick;
    check("sw_ready_back", 32'(req_ready), 32'd1);

    // 4. timeout with frozen status
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    repeat (6) tick;
    check("to_pre_mux_sel", 32'(mux_sel), 32'd0);
    model_en = 1'b0;
    done_base = done_cnt;
    req_sel = 1'b1;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    wait_evt(40, n, d, e);
    check("to_latency", 32'(n), 32'd16);
    check("to_err_seen", 32'(e), 32'd1);
    check("to_no_done", 32'(done_cnt - done_base), 32'd0);
    check("to_mux_revert", 32'(mux_sel), 32'd0);
    check("to_cur_sel", 32'(cur_sel), 32'd0);
    model_en = 1'b1;
    tick;
    check("to_err_pulse", 32'(sw_err), 32'd0);
    repeat (2) tick;

    // 5. reset during SETTLE
    done_base = done_cnt;
    err_base = err_cnt;
    req_sel = 1'b1;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (7) tick;
    check("rs_mux_pre", 32'(mux_sel), 32'd1);
    rst = 1'b1;
    tick;
    check("rs_mux_sel", 32'(mux_sel), 32'd0);
    check("rs_cur_sel", 32'(cur_sel), 32'd0);
    check("rs_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    repeat (8) tick;
    check("rs_idle", 32'(req_ready), 32'd1);
    check("rs_no_done", 32'(done_cnt - done_base), 32'd0);
    check("rs_no_err", 32'(err_cnt - err_base), 32'd0);

    // 6. request held through a busy switch
    acc_base = acc_cnt;
    done_base = done_cnt;
    tog_base = tog_cnt;
    req_sel = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 60 && (acc_cnt - acc_base) < 2; i++) tick;
    req_valid = 1'b0;
    repeat (3) tick;
    check("held_accepts", 32'(acc_cnt - acc_base), 32'd2);
    check("held_dones", 32'(done_cnt - done_base), 32'd2);
    check("held_toggles", 32'(tog_cnt - tog_base), 32'd1);
    check("held_cur_sel", 32'(cur_sel), 32'd1);
    check("held_mux_sel", 32'(mux_sel), 32'd1);

    check("no_done_err_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
